display_reader: RTL and testbench

DISPLAY_READER -- requirements
Module: display_reader

---
 rtl/disp_pkg.sv | 43 ++++
 rtl/seg7_encoder.sv | 27 ++
 rtl/display_reader.sv | 177 +++++++++++++++++
 tb/tb_display_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display reader: FSM states, segment
// codes, datapath widths and the double-dabble digit adjust.
package disp_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LATCH
  } state_t;

  // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp is never lit.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_T     = 8'h87;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Add 3 to every BCD digit >= 5 ahead of the left shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (res[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to active-low seven-segment decode; non-decimal
// inputs render blank.
module seg7_encoder
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_reader.sv
// Consumes 16-bit words from the CDC buffer, converts them to BCD with a
// sequential double-dabble, and multiplexes the result onto 8 digits.
module display_reader
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              data_2_valid,
  input  logic [DATA_W-1:0] data_2,
  input  logic              mode,
  output logic              parity,
  output logic [7:0]        an,
  output logic [7:0]        dec_cat
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]        r_step;
  logic [DATA_W-1:0] r_shift;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_conv_mode;
  logic              r_conv_par;

  logic              r_pend_vld;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_pend_mode;

  logic [BCD_W-1:0]  r_disp_bcd;
  logic              r_disp_mode;
  logic              r_parity;

  logic [CNT_W-1:0]  r_refresh_cnt;
  logic [2:0]        r_digit_idx;
  logic [7:0]        r_an;
  logic [7:0]        r_cat;

  logic              w_capture;
  logic [DATA_W-1:0] w_cap_data;
  logic              w_cap_mode;
  logic [BCD_W-1:0]  w_bcd_adj;

  logic              w_wrap;
  logic [2:0]        w_idx_nxt;
  logic [BCD_W-1:0]  w_bcd_view;
  logic              w_mode_view;
  logic [NUM_DIGITS-1:0] w_blank;
  logic              w_zero_run;
  logic [3:0]        w_enc_in;
  logic [7:0]        w_enc_seg;
  logic [7:0]        w_cat_nxt;

  // A fresh strobe in IDLE wins over any pending word.
  assign w_capture  = (r_state == ST_IDLE) && (data_2_valid || r_pend_vld);
  assign w_cap_data = data_2_valid ? data_2 : r_pend_data;
  assign w_cap_mode = data_2_valid ? mode   : r_pend_mode;
  assign w_bcd_adj  = dd_adjust(r_bcd);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_capture) w_state_nxt = ST_CONVERT;
      ST_CONVERT: if (r_step == 4'(DATA_W - 1)) w_state_nxt = ST_LATCH;
      ST_LATCH:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step      <= '0;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_conv_mode <= 1'b0;
      r_conv_par  <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_pend_mode <= 1'b0;
      r_disp_bcd  <= '0;
      r_disp_mode <= 1'b0;
      r_parity    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_shift     <= w_cap_data;
            r_conv_mode <= w_cap_mode;
            r_conv_par  <= ^w_cap_data;
            r_bcd       <= '0;
            r_step      <= '0;
            r_pend_vld  <= 1'b0;
          end
        end
        ST_CONVERT: begin
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_step           <= r_step + 4'd1;
        end
        ST_LATCH: begin
          r_disp_bcd  <= r_bcd;
          r_disp_mode <= r_conv_mode;
          r_parity    <= r_conv_par;
        end
        default: ;
      endcase

      if (data_2_valid && (r_state != ST_IDLE)) begin
        r_pend_vld  <= 1'b1;
        r_pend_data <= data_2;
        r_pend_mode <= mode;
      end
    end
  end

  assign w_wrap    = (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_idx_nxt = w_wrap ? r_digit_idx + 3'd1 : r_digit_idx;

  // Segments are decoded from the values the display registers take on this
  // edge, so a latched word reaches dec_cat on the same edge as parity.
  assign w_bcd_view  = (r_state == ST_LATCH) ? r_bcd       : r_disp_bcd;
  assign w_mode_view = (r_state == ST_LATCH) ? r_conv_mode : r_disp_mode;
  assign w_enc_in    = 4'(w_bcd_view >> {w_idx_nxt, 2'b00});

  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int unsigned i = BCD_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (w_bcd_view[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero_run;
    end
  end

  seg7_encoder u_seg7_encoder (
    .i_bcd (w_enc_in),
    .o_seg (w_enc_seg)
  );

  always_comb begin
    w_cat_nxt = SEG_BLANK;
    if (w_idx_nxt == 3'd7) begin
      w_cat_nxt = w_mode_view ? SEG_T : SEG_F;
    end else if (32'(w_idx_nxt) < BCD_DIGITS) begin
      if (!w_blank[w_idx_nxt]) w_cat_nxt = w_enc_seg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_an          <= '1;
      r_cat         <= SEG_BLANK;
    end else begin
      r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + 1'b1;
      r_digit_idx   <= w_idx_nxt;
      r_an          <= ~(8'b1 << w_idx_nxt);
      r_cat         <= w_cat_nxt;
    end
  end

  assign parity  = r_parity;
  assign an      = r_an;
  assign dec_cat = r_cat;

endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader: the stimulus side predicts when each
// word reaches the display, a negedge monitor checks every scanned digit.
module tb_display_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        data_2_valid = 1'b0;
  logic [15:0] data_2 = '0;
  logic        mode = 1'b0;
  logic        parity;
  logic [7:0]  an;
  logic [7:0]  dec_cat;

  display_reader #(.REFRESH_DIV(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_2_valid (data_2_valid),
    .data_2       (data_2),
    .mode         (mode),
    .parity       (parity),
    .an           (an),
    .dec_cat      (dec_cat)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned edge_no;
    int unsigned val;
    bit          md;
    bit          par;
  } upd_t;

  upd_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned edge_n = 0;

  logic [7:0] NUM [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Edges counted since the last reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int unsigned val, input bit md,
                                         input int unsigned idx);
    int unsigned p;
    p = 1;
    if (idx == 7) return md ? 8'h87 : 8'h8E;
    if (idx >= 5) return 8'hFF;
    for (int unsigned k = 0; k < idx; k++) p = p * 10;
    if (idx > 0 && val < p) return 8'hFF;
    return NUM[(val / p) % 10];
  endfunction

  // Monitor: adopt scheduled display updates and check the lit digit.
  int unsigned cur_val = 0;
  bit          cur_md  = 1'b0;
  bit          cur_par = 1'b0;
  upd_t        mon_u;
  int unsigned mon_idx;
  logic [7:0]  mon_an;

  always @(negedge clock) begin
    if (!reset) begin
      cur_val = 0;
      cur_md  = 1'b0;
      cur_par = 1'b0;
      sb.delete();
      check("rst_an", an, 8'hFF);
      check("rst_cat", dec_cat, 8'hFF);
      check("rst_parity", parity, 1'b0);
    end else if (edge_n == 0) begin
      check("post_rst_an", an, 8'hFF);
      check("post_rst_cat", dec_cat, 8'hFF);
    end else begin
      if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        mon_u   = sb.pop_front();
        cur_val = mon_u.val;
        cur_md  = mon_u.md;
        cur_par = mon_u.par;
      end
      mon_idx = (edge_n / 4) % 8;
      mon_an  = ~(8'b1 << mon_idx);
      check("an", an, mon_an);
      check("cat", dec_cat, exp_seg(cur_val, cur_md, mon_idx));
      check("parity", parity, cur_par);
    end
  end

  // Reference model: a word accepted on edge e shows on edge e+17 and the
  // converter accepts again from edge e+18; meanwhile the newest word waits.
  int unsigned free_at = 0;
  bit          pend_v  = 1'b0;
  int unsigned pend_val;
  bit          pend_md;

  task automatic accept(input int unsigned e, input logic [15:0] w, input bit md);
    sb.push_back('{e + 17, int'(w), md, ^w});
    free_at = e + 18;
    pend_v  = 1'b0;
  endtask

  task automatic step(input bit v, input logic [15:0] w, input bit md);
    int unsigned e;
    @(posedge clock);
    #1;
    data_2_valid = v;
    data_2       = w;
    mode         = md;
    e = edge_n + 1;
    if (e >= free_at) begin
      if (v)           accept(e, w, md);
      else if (pend_v) accept(e, 16'(pend_val), pend_md);
    end else if (v) begin
      pend_v   = 1'b1;
      pend_val = w;
      pend_md  = md;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset        = 1'b0;
    data_2_valid = 1'b0;
    #1;
    check("async_rst_an", an, 8'hFF);
    check("async_rst_cat", dec_cat, 8'hFF);
    check("async_rst_parity", parity, 1'b0);
    free_at = 0;
    pend_v  = 1'b0;
    sb.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    idle(40);

    step(1'b1, 16'd12345, 1'b0); idle(40);
    step(1'b1, 16'h0001, 1'b1);  idle(40);
    step(1'b1, 16'd65535, 1'b0); idle(40);
    step(1'b1, 16'd0, 1'b0);     idle(40);

    step(1'b1, 16'd100, 1'b0); idle(2);
    step(1'b1, 16'd200, 1'b0); idle(1);
    step(1'b1, 16'd300, 1'b0); idle(60);

    step(1'b1, 16'd9999, 1'b1); idle(7);
    do_reset();
    idle(40);

    repeat (40) begin
      step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 25));
    end
    idle(60);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
